// File: rtl/gaussian_kxk_stream_core_pkg.sv
// +--------------------------------------------------------------------------+
// | gaussian_kxk_stream_core_pkg                                              |
// | Shared constants and elaboration-time helpers for the KxK Gaussian core.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package gaussian_kxk_stream_core_pkg;

  localparam int unsigned c_KSIZE_MIN = 3;
  localparam int unsigned c_KSIZE_MAX = 7;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < v) w++;
    return w;
  endfunction

  // C(n,k) built incrementally so every intermediate quotient is exact
  function automatic int unsigned binom(input int unsigned n, input int unsigned k);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic int unsigned default_coeff(input int unsigned ksize,
                                                input int unsigned row,
                                                input int unsigned col);
    return binom(ksize - 1, row) * binom(ksize - 1, col);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gaussian_kxk_stream_core_pe.sv
// +--------------------------------------------------------------------------+
// | gaussian_kxk_stream_core_pe                                               |
// | One multiply-accumulate stage of a row chain; optionally unregistered.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module gaussian_kxk_stream_core_pe #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned COEFF_WIDTH = 8,
  parameter int unsigned ACCUM_WIDTH = 24,
  parameter bit          REGISTERED  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic                   i_clear,
  input  logic [ACCUM_WIDTH-1:0] i_acc_in,
  input  logic [PIXEL_WIDTH-1:0] i_pixel,
  input  logic [COEFF_WIDTH-1:0] i_coeff,
  output logic [ACCUM_WIDTH-1:0] o_acc_out
);

  logic [ACCUM_WIDTH-1:0] w_sum;

  assign w_sum = (i_clear ? '0 : i_acc_in) + ACCUM_WIDTH'(i_pixel) * ACCUM_WIDTH'(i_coeff);

  if (REGISTERED) begin : g_reg
    logic [ACCUM_WIDTH-1:0] r_acc;

    always_ff @(posedge clk) begin
      if (!rst_n)    r_acc <= '0;
      else if (i_en) r_acc <= w_sum;
    end

    assign o_acc_out = r_acc;
  end else begin : g_comb
    // last stage of a chain feeds the output rounding directly
    logic w_unused;
    assign w_unused  = ^{clk, rst_n, i_en};
    assign o_acc_out = w_sum;
  end

endmodule

`default_nettype wire

// File: rtl/gaussian_kxk_stream_core.sv
// +--------------------------------------------------------------------------+
// | gaussian_kxk_stream_core                                                  |
// | KxK convolution on a column-per-beat stream with double-buffered kernel.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module gaussian_kxk_stream_core
  import gaussian_kxk_stream_core_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned COEFF_WIDTH = 8,
  parameter int unsigned KSIZE       = 5,
  parameter int unsigned ACCUM_WIDTH = 24,
  parameter int unsigned NORM_SHIFT  = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_sol,
  input  logic [KSIZE*PIXEL_WIDTH-1:0]       in_col,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PIXEL_WIDTH-1:0]             pixel_out,
  input  logic                               bypass,
  input  logic                               coeff_we,
  input  logic [clog2(KSIZE*KSIZE)-1:0]      coeff_addr,
  input  logic [COEFF_WIDTH-1:0]             coeff_wdata,
  input  logic                               coeff_commit,
  output logic                               commit_pending
);

  localparam int unsigned c_NCOEF = KSIZE * KSIZE;
  localparam int unsigned c_AW    = clog2(c_NCOEF);
  localparam int unsigned c_FW    = clog2(KSIZE + 1);
  localparam int unsigned c_HALF  = (KSIZE - 1) / 2;

  localparam logic [c_FW-1:0]        c_FILL_FULL = c_FW'(KSIZE);
  localparam logic [c_FW-1:0]        c_FILL_ONE  = c_FW'(1);
  localparam logic [c_AW-1:0]        c_NCOEF_A   = c_AW'(c_NCOEF);
  localparam logic [ACCUM_WIDTH:0]   c_ROUND     = (ACCUM_WIDTH + 1)'(1) << (NORM_SHIFT - 1);
  localparam logic [ACCUM_WIDTH:0]   c_PIX_MAX   = (ACCUM_WIDTH + 1)'((1 << PIXEL_WIDTH) - 1);

  if (KSIZE < c_KSIZE_MIN || KSIZE > c_KSIZE_MAX || (KSIZE % 2) == 0) begin : g_ksize_check
    $error("KSIZE must be odd and within 3..7");
  end

  logic                   w_accept;
  logic                   w_apply;
  logic                   w_produce;
  logic [c_FW-1:0]        r_fill;
  logic [c_FW-1:0]        w_fill_next;
  logic [COEFF_WIDTH-1:0] r_active [c_NCOEF];
  logic [COEFF_WIDTH-1:0] r_shadow [c_NCOEF];
  logic [COEFF_WIDTH-1:0] w_coef   [c_NCOEF];
  logic [COEFF_WIDTH-1:0] w_def    [c_NCOEF];
  logic [ACCUM_WIDTH-1:0] w_acc    [KSIZE][KSIZE];
  logic [ACCUM_WIDTH-1:0] w_sum;
  logic [ACCUM_WIDTH:0]   w_rounded;
  logic [ACCUM_WIDTH:0]   w_shifted;
  logic [PIXEL_WIDTH-1:0] w_filt;
  logic [PIXEL_WIDTH-1:0] r_byp    [c_HALF];
  logic                   r_out_valid;
  logic [PIXEL_WIDTH-1:0] r_pixel_out;
  logic                   r_commit_pending;

  assign in_ready       = !r_out_valid || out_ready;
  assign w_accept       = in_valid && in_ready;
  assign w_apply        = w_accept && in_sol && r_commit_pending;
  assign w_fill_next    = in_sol ? c_FILL_ONE :
                          (r_fill == c_FILL_FULL) ? c_FILL_FULL : r_fill + c_FILL_ONE;
  assign w_produce      = w_accept && (w_fill_next == c_FILL_FULL);
  assign out_valid      = r_out_valid;
  assign pixel_out      = r_pixel_out;
  assign commit_pending = r_commit_pending;

  // The applying sol beat already runs on the shadow bank while it is being copied
  for (genvar gi = 0; gi < c_NCOEF; gi++) begin : g_coef
    localparam logic [COEFF_WIDTH-1:0] c_DEF =
      COEFF_WIDTH'(default_coeff(KSIZE, gi / KSIZE, gi % KSIZE));
    assign w_def[gi]  = c_DEF;
    assign w_coef[gi] = w_apply ? r_shadow[gi] : r_active[gi];
  end

  for (genvar gr = 0; gr < KSIZE; gr++) begin : g_row
    for (genvar gc = 0; gc < KSIZE; gc++) begin : g_col
      logic [ACCUM_WIDTH-1:0] w_acc_in;

      if (gc == 0) begin : g_first
        assign w_acc_in = '0;
      end else begin : g_chain
        assign w_acc_in = w_acc[gr][gc-1];
      end

      gaussian_kxk_stream_core_pe #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .COEFF_WIDTH (COEFF_WIDTH),
        .ACCUM_WIDTH (ACCUM_WIDTH),
        .REGISTERED  (gc != KSIZE - 1)
      ) u_pe (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_accept),
        .i_clear   (gc == 0),
        .i_acc_in  (w_acc_in),
        .i_pixel   (in_col[gr*PIXEL_WIDTH +: PIXEL_WIDTH]),
        .i_coeff   (w_coef[gr*KSIZE + gc]),
        .o_acc_out (w_acc[gr][gc])
      );
    end
  end

  always_comb begin
    w_sum = '0;
    for (int r = 0; r < KSIZE; r++) w_sum = w_sum + w_acc[r][KSIZE-1];
  end

  assign w_rounded = {1'b0, w_sum} + c_ROUND;
  assign w_shifted = w_rounded >> NORM_SHIFT;
  assign w_filt    = (w_shifted > c_PIX_MAX) ? '1 : w_shifted[PIXEL_WIDTH-1:0];

  // Centre-row delay so bypass lines up with the window centre column
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_HALF; i++) r_byp[i] <= '0;
    end else if (w_accept) begin
      r_byp[0] <= in_col[c_HALF*PIXEL_WIDTH +: PIXEL_WIDTH];
      for (int i = 1; i < c_HALF; i++) r_byp[i] <= r_byp[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fill           <= '0;
      r_out_valid      <= 1'b0;
      r_pixel_out      <= '0;
      r_commit_pending <= 1'b0;
      for (int i = 0; i < c_NCOEF; i++) begin
        r_active[i] <= w_def[i];
        r_shadow[i] <= w_def[i];
      end
    end else begin
      if (w_accept) begin
        r_fill      <= w_fill_next;
        r_out_valid <= w_produce;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_produce) r_pixel_out <= bypass ? r_byp[c_HALF-1] : w_filt;

      if (w_apply) begin
        r_commit_pending <= 1'b0;
        for (int i = 0; i < c_NCOEF; i++) r_active[i] <= r_shadow[i];
      end else if (coeff_commit) begin
        r_commit_pending <= 1'b1;
      end

      if (coeff_we && (coeff_addr < c_NCOEF_A)) r_shadow[coeff_addr] <= coeff_wdata;
    end
  end

endmodule

`default_nettype wire
